// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the counter-sizing helper.
package comparator_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_SCAN = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cmp_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational DIGIT-wide unsigned magnitude compare built from gate primitives.
// gt/lt are both low when the two digits are equal.
module digit_compare #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    wire [DIGIT-1:0] gt_chain;
    wire [DIGIT-1:0] lt_chain;

    // Ripple from LSB upward: a more significant unequal bit overrides lower ones.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        wire na, nb, bit_gt, bit_lt, bit_eq;
        not  u_na (na, a[i]);
        not  u_nb (nb, b[i]);
        and  u_gt (bit_gt, a[i], nb);
        and  u_lt (bit_lt, na, b[i]);
        xnor u_eq (bit_eq, a[i], b[i]);
        if (i == 0) begin : g_lsb
            buf u_gc (gt_chain[0], bit_gt);
            buf u_lc (lt_chain[0], bit_lt);
        end else begin : g_upper
            wire keep_gt, keep_lt;
            and u_kg (keep_gt, bit_eq, gt_chain[i-1]);
            and u_kl (keep_lt, bit_eq, lt_chain[i-1]);
            or  u_gc (gt_chain[i], bit_gt, keep_gt);
            or  u_lc (lt_chain[i], bit_lt, keep_lt);
        end
    end

    assign gt = gt_chain[DIGIT-1];
    assign lt = lt_chain[DIGIT-1];

endmodule

// File: rtl/serial_comparator.sv
// MSB-first serial magnitude comparator with early exit and registered relation flags.
// Optional two's-complement mode is enabled by defining SERIAL_CMP_SIGNED_EN.
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
`ifdef SERIAL_CMP_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic             aGTb,
    output logic             aGEb,
    output logic             aLTb,
    output logic             aLEb,
    output logic             aEQb,
    output logic             aNEb
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cmp_clog2(NDIG);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    cmp_state_t       state;
    cmp_state_t       next_state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [CNT_W-1:0] cnt;
    logic             dig_gt;
    logic             dig_lt;
    logic             last_dig;
    logic             accept;
    logic             finish;

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] sign_mask;
    assign sign_mask = {is_signed, {(WIDTH-1){1'b0}}};
    assign cap_a     = valA ^ sign_mask;
    assign cap_b     = valB ^ sign_mask;
`else
    assign cap_a = valA;
    assign cap_b = valB;
`endif

    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a  (sh_a[WIDTH-1 -: DIGIT]),
        .b  (sh_b[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    assign last_dig = (cnt == LAST_DIG);
    assign accept   = start && (state != CMP_SCAN);

    always_comb begin
        next_state = state;
        case (state)
            CMP_IDLE: begin
                if (start) next_state = CMP_SCAN;
            end
            CMP_SCAN: begin
                if (dig_gt || dig_lt || last_dig) next_state = CMP_DONE;
            end
            CMP_DONE: begin
                next_state = start ? CMP_SCAN : CMP_IDLE;
            end
            default: next_state = CMP_IDLE;
        endcase
    end

    assign finish = (state == CMP_SCAN) && (next_state == CMP_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CMP_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            aGTb  <= 1'b0;
            aGEb  <= 1'b0;
            aLTb  <= 1'b0;
            aLEb  <= 1'b0;
            aEQb  <= 1'b0;
            aNEb  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == CMP_SCAN);
            done  <= (next_state == CMP_DONE);

            if (accept) begin
                sh_a <= cap_a;
                sh_b <= cap_b;
                cnt  <= '0;
            end else if ((state == CMP_SCAN) && !finish) begin
                sh_a <= sh_a << DIGIT;
                sh_b <= sh_b << DIGIT;
                cnt  <= cnt + CNT_W'(1);
            end

            // Exiting without gt/lt only happens on the last digit, i.e. equality.
            if (finish) begin
                aGTb <= dig_gt;
                aLTb <= dig_lt;
                aEQb <= ~(dig_gt | dig_lt);
                aNEb <= dig_gt | dig_lt;
                aGEb <= ~dig_lt;
                aLEb <= ~dig_gt;
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized self-checking bench for serial_comparator (DIGIT=1 and DIGIT=4 instances)
// against an arithmetic reference model.
module tb_serial_comparator;

    localparam int NDIG = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       is_signed;
    logic [7:0] val_a;
    logic [7:0] val_b;
    logic       busy, done, gt, ge, lt, le, eq, ne;
    logic [5:0] obs;

    logic       start4;
    logic [7:0] val_a4;
    logic [7:0] val_b4;
    logic       busy4, done4, gt4, ge4, lt4, le4, eq4, ne4;
    logic [5:0] obs4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign obs  = {gt, ge, lt, le, eq, ne};
    assign obs4 = {gt4, ge4, lt4, le4, eq4, ne4};

    serial_comparator #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .valA  (val_a),
        .valB  (val_b),
`ifdef SERIAL_CMP_SIGNED_EN
        .is_signed (is_signed),
`endif
        .busy  (busy),
        .done  (done),
        .aGTb  (gt),
        .aGEb  (ge),
        .aLTb  (lt),
        .aLEb  (le),
        .aEQb  (eq),
        .aNEb  (ne)
    );

    serial_comparator #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .valA  (val_a4),
        .valB  (val_b4),
`ifdef SERIAL_CMP_SIGNED_EN
        .is_signed (1'b0),
`endif
        .busy  (busy4),
        .done  (done4),
        .aGTb  (gt4),
        .aGEb  (ge4),
        .aLTb  (lt4),
        .aLEb  (le4),
        .aEQb  (eq4),
        .aNEb  (ne4)
    );

    // 1-based index of the first differing digit from the MSB, or the digit count if equal.
    function automatic int first_diff(input logic [7:0] a, input logic [7:0] b, input int dig);
        int nd, sh, m;
        nd = 8 / dig;
        m  = (1 << dig) - 1;
        for (int d = 0; d < nd; d++) begin
            sh = 8 - dig * (d + 1);
            if (((int'(a) >> sh) & m) != ((int'(b) >> sh) & m)) return d + 1;
        end
        return nd;
    endfunction

    // Expected {GT, GE, LT, LE, EQ, NE}.
    function automatic logic [5:0] exp_flags(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        logic g, l, e;
        if (sgn) begin
            g = ($signed(a) > $signed(b));
            l = ($signed(a) < $signed(b));
        end else begin
            g = (a > b);
            l = (a < b);
        end
        e = (a == b);
        return {g, g | e, l, l | e, e, ~e};
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        start     = 1'b1;
        val_a     = a;
        val_b     = b;
        is_signed = sgn;
    endtask

    // Follows one accepted compare from edge 0 to its done cycle.
    task automatic finish_cmp(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                              input bit interfere, input bit chain,
                              input logic [7:0] na, input logic [7:0] nb, input logic nsgn,
                              input string name);
        int k;
        logic [5:0] ef;
        k  = first_diff(a, b, 1);
        ef = exp_flags(a, b, sgn);
        @(posedge clk);
        #1;
        start = 1'b0;
        val_a = 8'($urandom);
        val_b = 8'($urandom);
        for (int c = 1; c <= NDIG + 1; c++) begin
            @(negedge clk);
            if (c <= k) begin
                tests++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL %s busy/done cycle %0d got %b/%b want 1/0", name, c, busy, done);
                end
            end else begin
                tests++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    fails++;
                    $display("FAIL %s done cycle %0d busy/done got %b/%b want 0/1", name, c, busy, done);
                end
                tests++;
                if (obs !== ef) begin
                    fails++;
                    $display("FAIL %s flags a=%h b=%h got %b want %b", name, a, b, obs, ef);
                end
                if (chain) issue(na, nb, nsgn);
                break;
            end
            if (interfere && c == 2) begin
                start = 1'b1;
                val_a = 8'hFF;
                val_b = 8'h00;
            end else if (interfere && c == 3) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        start4 = 1'b0;
        val_a  = '0;
        val_b  = '0;
        val_a4 = '0;
        val_b4 = '0;
        is_signed = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || obs !== 6'b0) begin
            fails++;
            $display("FAIL reset busy/done/flags got %b/%b/%b want 0/0/000000", busy, done, obs);
        end
        tests++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || obs4 !== 6'b0) begin
            fails++;
            $display("FAIL reset4 busy/done/flags got %b/%b/%b want 0/0/000000", busy4, done4, obs4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        issue(8'h80, 8'h7F, 1'b0);
        finish_cmp(8'h80, 8'h7F, 1'b0, 0, 0, 8'h0, 8'h0, 1'b0, "gt_k1");
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || obs !== exp_flags(8'h80, 8'h7F, 1'b0)) begin
            fails++;
            $display("FAIL hold_idle done/flags got %b/%b want 0/%b", done, obs, exp_flags(8'h80, 8'h7F, 1'b0));
        end
        issue(8'h5A, 8'h5A, 1'b0);
        finish_cmp(8'h5A, 8'h5A, 1'b0, 0, 0, 8'h0, 8'h0, 1'b0, "eq_full");
        issue(8'h03, 8'h05, 1'b0);
        finish_cmp(8'h03, 8'h05, 1'b0, 0, 0, 8'h0, 8'h0, 1'b0, "lt_k6");
    endtask

    task automatic test_busy_ignore();
        issue(8'h11, 8'h11, 1'b0);
        finish_cmp(8'h11, 8'h11, 1'b0, 1, 0, 8'h0, 8'h0, 1'b0, "busy_ignore");
    endtask

    task automatic test_back_to_back();
        issue(8'hA1, 8'hB1, 1'b0);
        finish_cmp(8'hA1, 8'hB1, 1'b0, 0, 1, 8'h3C, 8'h3C, 1'b0, "b2b_first");
        finish_cmp(8'h3C, 8'h3C, 1'b0, 0, 1, 8'hC4, 8'hC0, 1'b0, "b2b_second");
        finish_cmp(8'hC4, 8'hC0, 1'b0, 0, 0, 8'h0, 8'h0, 1'b0, "b2b_third");
    endtask

    task automatic test_random();
        logic [7:0] ra[17];
        logic [7:0] rb[17];
        for (int i = 0; i < 17; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = (i % 4 == 0) ? ra[i] : 8'($urandom);
            if (i % 5 == 3) rb[i] = ra[i] ^ 8'h01;
        end
        issue(ra[0], rb[0], 1'b0);
        for (int i = 0; i < 16; i++) begin
            finish_cmp(ra[i], rb[i], 1'b0, 0, 1, ra[i+1], rb[i+1], 1'b0, "random");
        end
        finish_cmp(ra[16], rb[16], 1'b0, 0, 0, 8'h0, 8'h0, 1'b0, "random_last");
    endtask

    task automatic test_reset_mid_scan();
        issue(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || obs !== 6'b0) begin
            fails++;
            $display("FAIL mid_reset busy/done/flags got %b/%b/%b want 0/0/000000", busy, done, obs);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || obs !== 6'b0) begin
                fails++;
                $display("FAIL mid_reset_hold done/flags got %b/%b want 0/000000", done, obs);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h40, 8'h41, 1'b0);
        finish_cmp(8'h40, 8'h41, 1'b0, 0, 0, 8'h0, 8'h0, 1'b0, "after_reset");
    endtask

    task automatic test_signed();
`ifdef SERIAL_CMP_SIGNED_EN
        logic [7:0] a, b;
        issue(8'h80, 8'h01, 1'b1);
        finish_cmp(8'h80, 8'h01, 1'b1, 0, 0, 8'h0, 8'h0, 1'b0, "signed_neg");
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            issue(a, b, 1'b1);
            finish_cmp(a, b, 1'b1, 0, 0, 8'h0, 8'h0, 1'b0, "signed_random");
        end
`endif
        issue(8'h80, 8'h01, 1'b0);
        finish_cmp(8'h80, 8'h01, 1'b0, 0, 0, 8'h0, 8'h0, 1'b0, "unsigned_80_01");
    endtask

    task automatic test_digit4();
        logic [7:0] a, b;
        int k;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                a = 8'h12; b = 8'h13;
            end else begin
                a = 8'($urandom);
                b = (i % 3 == 0) ? a : 8'($urandom);
            end
            k = first_diff(a, b, 4);
            start4 = 1'b1;
            val_a4 = a;
            val_b4 = b;
            @(posedge clk);
            #1;
            start4 = 1'b0;
            val_a4 = 8'($urandom);
            val_b4 = 8'($urandom);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                tests++;
                if (c <= k) begin
                    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                        fails++;
                        $display("FAIL digit4 busy/done cycle %0d got %b/%b want 1/0", c, busy4, done4);
                    end
                end else begin
                    if (done4 !== 1'b1 || obs4 !== exp_flags(a, b, 1'b0)) begin
                        fails++;
                        $display("FAIL digit4 a=%h b=%h done/flags got %b/%b want 1/%b",
                                 a, b, done4, obs4, exp_flags(a, b, 1'b0));
                    end
                    break;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_scan();
        test_signed();
        test_digit4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
